// File: rtl/l2_pkg.sv
// l2_pkg: values shared by the L2 arbiter and its testbench.
//   DEF_ADDR_W / DEF_DATA_W / DEF_CNT_W : default widths (block address, cache block, statistics counter)
//   state_t  : arbiter FSM encoding (IDLE, BUSY_I, BUSY_D)
//   grant_t  : identifies which L1 side was served last
package l2_pkg;

   localparam int DEF_ADDR_W = 28;   // 30-bit word address minus 2 offset bits
   localparam int DEF_DATA_W = 128;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that stops at all ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {W{1'b1}})) begin
         count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 port between the L1-I and L1-D caches.
//   clk, rst                     : clock and synchronous active-high reset
//   i_read, i_addr               : L1-I block read request
//   i_rdata, i_ready             : L1-I read data and one-cycle completion pulse
//   d_read, d_write, d_addr,
//   d_wdata                      : L1-D read / write-back request
//   d_rdata, d_ready             : L1-D read data and one-cycle completion pulse
//   l2_read, l2_write, l2_addr,
//   l2_wdata                     : request to L2, driven only from latched registers
//   l2_rdata, l2_ready           : L2 response
//   cnt_i, cnt_d, cnt_conflict   : saturating grant / tie statistics
//   proto_err                    : sticky, set when d_read and d_write are seen together
// Requests are sampled only in IDLE; ties go to the side not served last.
module l2_arbiter
   import l2_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [DATA_W-1:0] l2_wdata,
   input  logic [DATA_W-1:0] l2_rdata,
   input  logic              l2_ready,
   output logic [CNT_W-1:0]  cnt_i,
   output logic [CNT_W-1:0]  cnt_d,
   output logic [CNT_W-1:0]  cnt_conflict,
   output logic              proto_err
);

   state_t            state_reg, state_next;
   grant_t            last_grant_reg, last_grant_next;
   logic              lat_write_reg, lat_write_next;
   logic [ADDR_W-1:0] lat_addr_reg, lat_addr_next;
   logic [DATA_W-1:0] lat_wdata_reg, lat_wdata_next;
   logic              proto_err_reg;

   logic i_req, d_req;
   logic grant_i, grant_d, conflict;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         last_grant_reg <= GRANT_D;   // I wins the first tie
         lat_write_reg  <= 1'b0;
         lat_addr_reg   <= '0;
         lat_wdata_reg  <= '0;
         proto_err_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         lat_write_reg  <= lat_write_next;
         lat_addr_reg   <= lat_addr_next;
         lat_wdata_reg  <= lat_wdata_next;
         if (d_read && d_write) begin
            proto_err_reg <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      lat_write_next  = lat_write_reg;
      lat_addr_next   = lat_addr_reg;
      lat_wdata_next  = lat_wdata_reg;
      grant_i         = 1'b0;
      grant_d         = 1'b0;
      conflict        = 1'b0;
      i_ready         = 1'b0;
      d_ready         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // l2_ready is deliberately ignored here
            if (i_req && d_req) begin
               conflict = 1'b1;
               if (last_grant_reg == GRANT_D) begin
                  grant_i = 1'b1;
               end else begin
                  grant_d = 1'b1;
               end
            end else if (i_req) begin
               grant_i = 1'b1;
            end else if (d_req) begin
               grant_d = 1'b1;
            end

            if (grant_i) begin
               state_next     = ST_BUSY_I;
               lat_write_next = 1'b0;
               lat_addr_next  = i_addr;
            end
            if (grant_d) begin
               // read+write together is treated as a write
               state_next     = ST_BUSY_D;
               lat_write_next = d_write;
               lat_addr_next  = d_addr;
               lat_wdata_next = d_wdata;
            end
         end

         ST_BUSY_I: begin
            if (l2_ready) begin
               i_ready         = ~rst;   // an abandoned transaction never reports done
               state_next      = ST_IDLE;
               last_grant_next = GRANT_I;
            end
         end

         ST_BUSY_D: begin
            if (l2_ready) begin
               d_ready         = ~rst;
               state_next      = ST_IDLE;
               last_grant_next = GRANT_D;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // L2 strobes decode the state register and the latched type only.
   assign l2_read   = (state_reg == ST_BUSY_I) || ((state_reg == ST_BUSY_D) && !lat_write_reg);
   assign l2_write  = (state_reg == ST_BUSY_D) && lat_write_reg;
   assign l2_addr   = lat_addr_reg;
   assign l2_wdata  = lat_wdata_reg;
   assign i_rdata   = l2_rdata;
   assign d_rdata   = l2_rdata;
   assign proto_err = proto_err_reg;

   sat_counter #(.W(CNT_W)) u_cnt_i (
      .clk   (clk),
      .rst   (rst),
      .inc   (grant_i),
      .count (cnt_i)
   );

   sat_counter #(.W(CNT_W)) u_cnt_d (
      .clk   (clk),
      .rst   (rst),
      .inc   (grant_d),
      .count (cnt_d)
   );

   sat_counter #(.W(CNT_W)) u_cnt_conflict (
      .clk   (clk),
      .rst   (rst),
      .inc   (conflict),
      .count (cnt_conflict)
   );

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter ADDR_W, 28, block address width (30-bit word address minus 2 offset bits).
REQ-002 Parameter DATA_W, 128, cache block width.
REQ-003 Parameter CNT_W, 16, width of each statistics counter.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; the ports are clk and rst.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge active.
- rst  in  1  synchronous reset, active high.
- i_read  in  1  L1-I block read request.
- i_addr  in  ADDR_W  L1-I block address.
- i_rdata  out  DATA_W  L1-I read data.
- i_ready  out  1  L1-I transaction done.
- d_read  in  1  L1-D block read request.
- d_write  in  1  L1-D block write-back request.
- d_addr  in  ADDR_W  L1-D block address.
- d_wdata  in  DATA_W  L1-D write data.
- d_rdata  out  DATA_W  L1-D read data.
- d_ready  out  1  L1-D transaction done.
- l2_read  out  1  read strobe to L2.
- l2_write  out  1  write strobe to L2.
- l2_addr  out  ADDR_W  address to L2.
- l2_wdata  out  DATA_W  write data to L2.
- l2_rdata  in  DATA_W  L2 read data.
- l2_ready  in  1  L2 transaction done.
- cnt_i  out  CNT_W  granted L1-I transactions.
- cnt_d  out  CNT_W  granted L1-D transactions.
- cnt_conflict  out  CNT_W  cycles in which both sides requested in IDLE.
- proto_err  out  1  sticky flag: d_read and d_write were asserted together.

Function
REQ-006 FSM states: IDLE, BUSY_I, BUSY_D.
REQ-007 IDLE with only the I side requesting: the next state SHALL be BUSY_I.
REQ-008 IDLE with only the D side requesting (d_read or d_write): the next state SHALL be BUSY_D.
REQ-009 IDLE with both sides requesting: the side not granted last SHALL win (round-robin), and cnt_conflict SHALL increment.
REQ-010 On a grant, the request is latched into registers: type, address and wdata. l2_read, l2_write, l2_addr and l2_wdata SHALL be driven only from these registers.
REQ-011 Register use in BUSY_I: l2_read=1, l2_write=0. Register use in BUSY_D: the latched type.
REQ-012 In IDLE, l2_read and l2_write SHALL be 0, l2_addr SHALL hold its last value, and l2_wdata SHALL hold its last value.
REQ-013 In BUSY_x, the outputs SHALL stay stable until l2_ready=1.
REQ-014 In the l2_ready cycle, x_ready SHALL be 1 combinationally, for that cycle only.
REQ-015 The cycle after l2_ready, the next state SHALL be IDLE and last_grant SHALL equal x.
REQ-016 i_rdata and d_rdata SHALL both equal l2_rdata at all times; only ready is gated.
REQ-017 The ready of the requester that is not granted SHALL be 0 always.
REQ-018 l2_ready in IDLE SHALL be ignored.
REQ-019 Latency:
- 1 arbitration cycle, plus the L2 latency, plus 1 return-to-IDLE cycle before the next grant.
- Minimum gap between grants: 2 cycles after l2_ready.
REQ-020 Requesters SHALL hold their request until ready. The arbiter samples a new request only in IDLE.
REQ-021 Request changes while the other side is busy SHALL have no effect until IDLE.
REQ-022 d_read and d_write asserted together SHALL be treated as a write and SHALL set proto_err.
REQ-023 Counters SHALL increment by 1 on grant, or on conflict for cnt_conflict, and saturate at all ones; they never wrap.
REQ-024 l2_ready arriving in the same cycle as a new request SHALL complete the current transaction; the new request is arbitrated in the following IDLE cycle.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL take these values:
- state IDLE;
- last_grant=D, so I wins the first tie;
- latched registers 0;
- counters 0;
- proto_err 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction: l2_read, l2_write, i_ready and d_ready SHALL be 0 from the next cycle, with no ready pulse issued.
REQ-027 Output values after reset: l2_addr=0, l2_wdata=0, and every output 0.

Structure
REQ-028 ADDR_W, DATA_W and CNT_W defaults, plus the state encoding, SHALL live in shared package l2_pkg.
REQ-029 The saturating counter SHALL be one sub-module, sat_counter, instantiated three times. All other logic stays in l2_arbiter.

Verification
REQ-030 I read only, addr 28'h0000123, L2 responds after 4 cycles:
- l2_read=1 with l2_addr=0000123 from cycle 1;
- i_ready pulses in the l2_ready cycle;
- cnt_i=1.
REQ-031 Simultaneous I and D requests just after reset: BUSY_I, then BUSY_D, cnt_conflict=1, and d_ready fires only after the I transaction completes.
REQ-032 Both sides request continuously for 6 transactions: grants alternate I,D,I,D,I,D, and cnt_i=cnt_d=3.
REQ-033 D write, d_wdata=128'hDEAD...BEEF, with d_wdata changed mid-transaction: l2_wdata keeps its latched value and l2_write=1 until l2_ready.
REQ-034 rst asserted in cycle 2 of BUSY_D: the next cycle is IDLE with l2_write=0, no d_ready, and all counters 0.
REQ-035 d_read=d_write=1: a write is issued and proto_err=1, staying set until rst.
REQ-036 Saturation: 65537 I grants leave cnt_i=16'hFFFF.
